// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ID/EX branch tracking, misprediction flush/redirect and predictor update.
module branch_resolver #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_branch_i,
  input  logic             id_predict_i,
  input  logic [PC_W-1:0]  id_pc_i,
  input  logic [PC_W-1:0]  id_target_i,
  input  logic             stall_i,
  input  logic             ex_taken_i,
  output logic             update_o,
  output logic             result_o,
  output logic             flush_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  logic            ex_valid;
  logic            ex_pred;
  logic [PC_W-1:0] ex_fallthru;
  logic [PC_W-1:0] ex_target;
  logic            resolve;

  // A branch held by a stall resolves only in its first unstalled cycle.
  assign resolve       = ex_valid & ~stall_i;
  assign update_o      = resolve;
  assign result_o      = resolve & ex_taken_i;
  assign flush_o       = resolve & (ex_pred != ex_taken_i);
  assign redirect_pc_o = flush_o ? (ex_taken_i ? ex_target : ex_fallthru) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid    <= 1'b0;
      ex_pred     <= 1'b0;
      ex_fallthru <= '0;
      ex_target   <= '0;
    end else if (!stall_i) begin
      if (flush_o) begin
        // The instruction in ID is wrong-path; drop it.
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_branch_i;
        if (id_branch_i) begin
          ex_pred     <= id_predict_i;
          ex_fallthru <= id_pc_i + PC_W'(4);
          ex_target   <= id_target_i;
        end
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (resolve && (branch_cnt_o != '1)) begin
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      end
      if (flush_o && (mispredict_cnt_o != '1)) begin
        mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver.
module tb_branch_resolver;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_branch, id_predict, stall, ex_taken;
  logic [PC_W-1:0]  id_pc, id_target;
  logic             update, result, flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  branch_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_branch_i(id_branch), .id_predict_i(id_predict),
    .id_pc_i(id_pc), .id_target_i(id_target),
    .stall_i(stall), .ex_taken_i(ex_taken),
    .update_o(update), .result_o(result), .flush_o(flush),
    .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt), .mispredict_cnt_o(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            pred;
    logic [PC_W-1:0] fall;
    logic [PC_W-1:0] tgt;
  } br_t;

  br_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_bcnt = 0;
  int  exp_mcnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_update"}, update, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_redirect"}, redirect_pc, 0);
    check({tag, "_bcnt"}, branch_cnt, 0);
    check({tag, "_mcnt"}, mispredict_cnt, 0);
  endtask

  // Called just after a rising edge; drives one cycle, checks mid-cycle, then advances.
  task automatic step(input logic br, input logic pred, input logic [PC_W-1:0] pc,
                      input logic [PC_W-1:0] tgt, input logic stl, input logic tk);
    logic            res, fl;
    logic [PC_W-1:0] rpc;
    br_t             e;
    id_branch  = br;
    id_predict = pred;
    id_pc      = pc;
    id_target  = tgt;
    stall      = stl;
    ex_taken   = tk;
    #4;
    res = (sb.size() > 0) && !stl;
    fl  = 1'b0;
    rpc = '0;
    if (res) begin
      e   = sb[0];
      fl  = (e.pred != tk);
      rpc = fl ? (tk ? e.tgt : e.fall) : '0;
    end
    check("update", update, res);
    check("result", result, res & tk);
    check("flush", flush, fl);
    check("redirect", redirect_pc, rpc);
    check("branch_cnt", branch_cnt, exp_bcnt);
    check("mispredict_cnt", mispredict_cnt, exp_mcnt);
    @(posedge clk);
    #1;
    if (res) begin
      void'(sb.pop_front());
      if (exp_bcnt < SAT) exp_bcnt++;
      if (fl && exp_mcnt < SAT) exp_mcnt++;
    end
    if (!stl && !fl && br) sb.push_back('{pred, pc + 32'd4, tgt});
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    id_branch  = 1'b0;
    id_predict = 1'b0;
    id_pc      = '0;
    id_target  = '0;
    stall      = 1'b0;
    ex_taken   = 1'b0;
    #1;
    check_zero_outputs("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_bcnt = 0;
    exp_mcnt = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    step(0, 0, 0, 0, 0, 1);

    // correct prediction, taken
    step(1, 1, 32'h100, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // mispredict, actually not taken
    step(1, 1, 32'h100, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // mispredict, actually taken, then wrapping fall-through
    step(1, 0, 32'hFFFF_FFFC, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 32'hFFFF_FFFC, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // flush kills the branch sitting in ID
    step(1, 1, 32'h300, 32'h400, 0, 0);
    step(1, 0, 32'h500, 32'h600, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // stall holds a branch for 3 cycles
    step(1, 0, 32'h700, 32'h800, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // back-to-back correctly predicted branches
    step(1, 1, 32'h1000, 32'h2000, 0, 0);
    step(1, 0, 32'h1004, 32'h3000, 0, 1);
    step(1, 1, 32'h1008, 32'h4000, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 32'(i * 8), 32'h8000, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    check("sat_branch_cnt", branch_cnt, SAT);
    check("sat_mispredict_cnt", mispredict_cnt, SAT);

    // reset asserted mid-cycle while a mispredict is in flight
    step(1, 0, 32'h900, 32'hA00, 0, 0);
    id_branch = 1'b1;
    id_pc     = 32'hB00;
    ex_taken  = 1'b1;
    #4;
    check("pre_rst_flush", flush, 1);
    check("pre_rst_redirect", redirect_pc, 32'hA00);
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    sb.delete();
    exp_bcnt  = 0;
    exp_mcnt  = 0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution unit for the 5-stage pipeline: the producer side of the predictor's update interface. It captures each decoded branch and its prediction in ID, carries them into EX, compares the prediction with the EX comparator outcome, and drives the predictor's update and result inputs. On a misprediction it raises a one-cycle flush and redirect PC to the fetch stage. It also keeps saturating branch and misprediction counters.

## Interface

**Parameters**
- `PC_W`, default 32: PC and target width.
- `CNT_W`, default 32: performance counter width.

**Ports**
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: asynchronous reset, active-high.
- `id_branch_i`  in  1: the instruction in ID is a conditional branch.
- `id_predict_i`  in  1: predictor output for that branch (1 = taken).
- `id_pc_i`  in  PC_W: PC of the branch in ID.
- `id_target_i`  in  PC_W: computed taken-target of the branch in ID.
- `stall_i`  in  1: pipeline stall; ID/EX contents are held.
- `ex_taken_i`  in  1: EX comparator outcome for the branch now in EX.
- `update_o`  out  1: predictor update strobe (one cycle per resolved branch).
- `result_o`  out  1: actual outcome driven to the predictor.
- `flush_o`  out  1: misprediction; kill IF/ID instructions.
- `redirect_pc_o`  out  PC_W: correct next PC, valid when `flush_o` = 1.
- `branch_cnt_o`  out  CNT_W: resolved-branch count.
- `mispredict_cnt_o`  out  CNT_W: misprediction count.

## Operation

**ID/EX state register**
- Fields: `ex_valid`, `ex_pred`, `ex_fallthru` (= `id_pc_i + 4`, mod 2^PC_W, wraps silently), `ex_target`.
- Update priority, highest first:
  - Stall: `stall_i` = 1 → hold all fields.
  - Flush: `flush_o` = 1 → `ex_valid` ← 0. The ID instruction is wrong-path and is dropped.
  - Otherwise: `ex_valid` ← `id_branch_i`. When `id_branch_i` = 1, load the other fields from the ID inputs.

**Resolution (combinational from state and `ex_taken_i`)**
- `resolve` = `ex_valid` & ~`stall_i`.
- `update_o` = `resolve`.
- `result_o` = `ex_taken_i` when `resolve`, else 0.
- `flush_o` = `resolve` & (`ex_pred` ≠ `ex_taken_i`).
- `redirect_pc_o` = `ex_taken_i` ? `ex_target` : `ex_fallthru` when `flush_o`, else 0.

**Counters**
- `branch_cnt_o` increments on each `resolve`.
- `mispredict_cnt_o` increments on each `flush_o`.
- Both saturate at 2^CNT_W−1 and never wrap.

**Stall behaviour**
- A branch held in EX by a stall resolves exactly once: in the first cycle with `stall_i` = 0.

## Timing

- Reset (async, immediate): `ex_valid` = 0, all other fields 0, both counters 0. All outputs are therefore 0 throughout reset and in the first cycle after it.
- Branch enters ID in cycle n with `stall_i` = 0 → `update_o`, `result_o`, `flush_o` and `redirect_pc_o` are valid in cycle n+1, combinationally from `ex_taken_i`.
- The predictor state and the counters change at the end of cycle n+1.
- `flush_o` is high for exactly one cycle per mispredict. The fetch stage loads `redirect_pc_o` at the same edge.
- Back-to-back branches, one per cycle, are each resolved; one `update_o` pulse each.
- A branch in ID during a flush cycle is discarded: no update and no count for it.
- Reset mid-stall or mid-flush clears everything. No pending update survives reset.
- `stall_i` and `flush_o` cannot both be 1, because `flush_o` is gated by ~`stall_i`.

## Test plan

1. **Correct prediction.** Reset, then ID: branch=1, predict=1, pc=0x100, target=0x200; next cycle `ex_taken_i`=1 → `update_o`=1, `result_o`=1, `flush_o`=0; counters 1/0.
2. **Mispredict, actually not taken.** predict=1, pc=0x100, target=0x200; `ex_taken_i`=0 → `flush_o`=1, `redirect_pc_o`=0x104, `result_o`=0; `mispredict_cnt_o`=1.
3. **Mispredict, actually taken.** predict=0, pc=0xFFFFFFFC, target=0x40; `ex_taken_i`=1 → `redirect_pc_o`=0x40. Repeat with `ex_taken_i`=0 and predict=1 → `redirect_pc_o`=0x0 (fall-through wraps).
4. **Flush kills the following branch.** Branch A mispredicts while branch B sits in ID → next cycle `update_o`=0; `branch_cnt_o` increases by 1 only.
5. **Stall.** Branch in EX with `stall_i`=1 for 3 cycles → `update_o`=0 throughout; the pulse appears once, in the cycle after stall drops; `branch_cnt_o` +1.
6. **Saturation and reset.** With CNT_W=4, resolve 20 mispredicted branches → both counters read 15. Assert `rst_i` mid-cycle → all outputs read 0 immediately.
